// File: rtl/exec_pkg.sv
// Shared decode constants, state and ALU enums for the multi-cycle RV32I execute unit.
package exec_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, WB} state_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;

  function automatic logic [1:0] shift_kind(input alu_op_e op);
    case (op)
      ALU_SRL: return SH_SRL;
      ALU_SRA: return SH_SRA;
      default: return SH_SLL;
    endcase
  endfunction

endpackage

// File: rtl/exec_unit_mc_iter_shifter.sv
// Iterative shifter: moves up to SHIFT_STEP bits per cycle until the loaded amount is consumed.
module iter_shifter
  import exec_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [4:0]  amount,
  input  logic [1:0]  kind,
  output logic [31:0] result,
  output logic        finished
);

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  logic [31:0] r_val;
  logic [5:0]  r_rem;
  logic [1:0]  r_kind;
  logic [5:0]  w_step;
  logic [31:0] w_next;

  // One step of min(STEP, remaining); repeated arithmetic shifts keep replicating bit 31.
  always_comb begin
    w_step = (r_rem < STEP) ? r_rem : STEP;
    w_next = r_val;
    case (r_kind)
      SH_SLL:  w_next = r_val << w_step;
      SH_SRL:  w_next = r_val >> w_step;
      SH_SRA:  w_next = $unsigned($signed(r_val) >>> w_step);
      default: w_next = r_val;
    endcase
  end

  // Shifter state: load captures operands, otherwise step while work remains.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_val  <= 32'h0000_0000;
      r_rem  <= 6'd0;
      r_kind <= SH_SLL;
    end else if (load) begin
      r_val  <= value;
      r_rem  <= {1'b0, amount};
      r_kind <= kind;
    end else if (r_rem != 6'd0) begin
      r_val <= w_next;
      r_rem <= r_rem - w_step;
    end
  end

  assign result   = r_val;
  assign finished = (r_rem != 6'd0) && (r_rem <= STEP);

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle RV32I/RV32E execute and writeback unit with its own register file.
module exec_unit_mc
  import exec_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_next,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int         AW      = $clog2(NREGS);
  localparam logic [5:0] NREGS_W = 6'(NREGS);

  state_e      r_state;
  logic [31:0] r_instr;
  logic [31:0] r_pc_next;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_use_sh;
  logic        r_wr_en;
  logic        r_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_illegal;
  logic [31:0] r_regs [NREGS];

  logic [6:0]  w_opc;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_f7;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_op_b;
  logic [31:0] w_alu_res;
  logic [31:0] w_result;
  alu_op_e     w_alu_op;
  logic        w_legal;
  logic        w_is_shift;
  logic        w_sh_load;
  logic [31:0] w_sh_result;
  logic        w_sh_finished;

  function automatic logic reg_ok(input logic [4:0] addr);
    return {1'b0, addr} < NREGS_W;
  endfunction

  assign w_opc = r_instr[6:0];
  assign w_rd  = r_instr[11:7];
  assign w_f3  = r_instr[14:12];
  assign w_rs1 = r_instr[19:15];
  assign w_rs2 = r_instr[24:20];
  assign w_f7  = r_instr[31:25];
  assign w_imm = {{20{r_instr[31]}}, r_instr[31:20]};

  // Register read ports; x0 and out-of-range indices read as zero.
  always_comb begin
    w_rs1_val = 32'h0000_0000;
    w_rs2_val = 32'h0000_0000;
    if ((w_rs1 != 5'd0) && reg_ok(w_rs1)) begin
      w_rs1_val = r_regs[w_rs1[AW-1:0]];
    end else begin
      w_rs1_val = 32'h0000_0000;
    end
    if ((w_rs2 != 5'd0) && reg_ok(w_rs2)) begin
      w_rs2_val = r_regs[w_rs2[AW-1:0]];
    end else begin
      w_rs2_val = 32'h0000_0000;
    end
  end

  // Decode and legality check of the latched instruction word.
  always_comb begin
    w_alu_op = ALU_ADD;
    w_legal  = 1'b0;
    w_op_b   = w_imm;
    case (w_opc)
      OPC_OP_IMM: begin
        w_legal = reg_ok(w_rd) && reg_ok(w_rs1);
        case (w_f3)
          F3_ADD:  w_alu_op = ALU_ADD;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_SLTU: w_alu_op = ALU_SLTU;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          F3_SLL: begin
            w_alu_op = ALU_SLL;
            w_legal  = w_legal && (w_f7 == F7_BASE);
          end
          F3_SR: begin
            w_alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            w_legal  = w_legal && ((w_f7 == F7_BASE) || (w_f7 == F7_ALT));
          end
          default: w_alu_op = ALU_ADD;
        endcase
      end
      OPC_OP: begin
        w_op_b  = w_rs2_val;
        w_legal = reg_ok(w_rd) && reg_ok(w_rs1) && reg_ok(w_rs2) &&
                  ((w_f7 == F7_BASE) ||
                   ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD) || (w_f3 == F3_SR))));
        case (w_f3)
          F3_ADD:  w_alu_op = (w_f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:  w_alu_op = ALU_SLL;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_SLTU: w_alu_op = ALU_SLTU;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_SR:   w_alu_op = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_alu_op = ALU_ADD;
        endcase
      end
      OPC_LUI: w_legal = reg_ok(w_rd);
      OPC_JAL: w_legal = reg_ok(w_rd);
      default: w_legal = 1'b0;
    endcase
  end

  assign w_is_shift = ((w_opc == OPC_OP_IMM) || (w_opc == OPC_OP)) &&
                      ((w_alu_op == ALU_SLL) || (w_alu_op == ALU_SRL) || (w_alu_op == ALU_SRA));
  assign w_sh_load  = (r_state == EXEC) && w_legal && w_is_shift && (w_op_b[4:0] != 5'd0);

  // Single-cycle ALU; a shift by zero passes rs1 straight through.
  always_comb begin
    w_alu_res = 32'h0000_0000;
    case (w_alu_op)
      ALU_ADD:  w_alu_res = w_rs1_val + w_op_b;
      ALU_SUB:  w_alu_res = w_rs1_val - w_op_b;
      ALU_SLT:  w_alu_res = {31'h0, $signed(w_rs1_val) < $signed(w_op_b)};
      ALU_SLTU: w_alu_res = {31'h0, w_rs1_val < w_op_b};
      ALU_XOR:  w_alu_res = w_rs1_val ^ w_op_b;
      ALU_OR:   w_alu_res = w_rs1_val | w_op_b;
      ALU_AND:  w_alu_res = w_rs1_val & w_op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: w_alu_res = w_rs1_val;
      default:  w_alu_res = 32'h0000_0000;
    endcase
    case (w_opc)
      OPC_LUI: w_result = {r_instr[31:12], 12'h000};
      OPC_JAL: w_result = r_pc_next;
      default: w_result = w_alu_res;
    endcase
  end

  iter_shifter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_sh_load),
    .value    (w_rs1_val),
    .amount   (w_op_b[4:0]),
    .kind     (shift_kind(w_alu_op)),
    .result   (w_sh_result),
    .finished (w_sh_finished)
  );

  // Control FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_instr   <= 32'h0000_0000;
      r_pc_next <= 32'h0000_0000;
      r_result  <= 32'h0000_0000;
      r_rd      <= 5'd0;
      r_use_sh  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          if (instr_valid) begin
            r_instr   <= instruction;
            r_pc_next <= pc_next;
            r_state   <= EXEC;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        EXEC: begin
          r_result <= w_result;
          r_rd     <= w_rd;
          r_wr_en  <= w_legal && (w_rd != 5'd0);
          r_use_sh <= w_sh_load;
          if (w_sh_load) begin
            r_state <= SHIFT;
          end else begin
            r_state   <= WB;
            r_done    <= 1'b1;
            r_illegal <= !w_legal;
          end
        end
        SHIFT: begin
          if (w_sh_finished) begin
            r_state <= WB;
            r_done  <= 1'b1;
          end
        end
        WB: begin
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
        end
        default: begin
          r_state   <= IDLE;
          r_done    <= 1'b0;
          r_illegal <= 1'b0;
          r_busy    <= 1'b0;
          r_ready   <= 1'b1;
        end
      endcase
    end
  end

  // Register file: cleared on reset, written at the end of WB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else if ((r_state == WB) && r_wr_en) begin
      r_regs[r_rd[AW-1:0]] <= r_use_sh ? w_sh_result : r_result;
    end
  end

  assign dbg_data    = ((dbg_addr != 5'd0) && reg_ok(dbg_addr)) ? r_regs[dbg_addr[AW-1:0]] : 32'h0000_0000;
  assign instr_ready = r_ready;
  assign busy        = r_busy;
  assign done        = r_done;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: three instances cover RV32I/step 1, RV32I/step 4 and RV32E.
module tb_exec_unit_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld  [3];
  logic [31:0] ins_a[3];
  logic [31:0] pc_a [3];
  logic [4:0]  dba  [3];
  logic        rdy  [3];
  logic        bsy  [3];
  logic        dn   [3];
  logic        ill  [3];
  logic [31:0] dbd  [3];

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] LOAD   = 7'b0000011;

  always #5 clk = ~clk;

  exec_unit_mc #(.NREGS(32), .SHIFT_STEP(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .instr_valid(vld[0]), .instr_ready(rdy[0]),
    .instruction(ins_a[0]), .pc_next(pc_a[0]), .busy(bsy[0]), .done(dn[0]),
    .illegal(ill[0]), .dbg_addr(dba[0]), .dbg_data(dbd[0]));

  exec_unit_mc #(.NREGS(32), .SHIFT_STEP(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .instr_valid(vld[1]), .instr_ready(rdy[1]),
    .instruction(ins_a[1]), .pc_next(pc_a[1]), .busy(bsy[1]), .done(dn[1]),
    .illegal(ill[1]), .dbg_addr(dba[1]), .dbg_data(dbd[1]));

  exec_unit_mc #(.NREGS(16), .SHIFT_STEP(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(vld[2]), .instr_ready(rdy[2]),
    .instruction(ins_a[2]), .pc_next(pc_a[2]), .busy(bsy[2]), .done(dn[2]),
    .illegal(ill[2]), .dbg_addr(dba[2]), .dbg_data(dbd[2]));

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rd, opc};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input int d, input logic [4:0] addr, input logic [31:0] exp,
                           input string tag);
    dba[d] = addr;
    #1;
    check_eq(tag, dbd[d], exp);
  endtask

  // Issue one instruction and check latency, illegal flag and single-cycle done.
  task automatic issue(input int d, input logic [31:0] ins, input logic [31:0] pcn,
                       input string tag, input int exp_lat, input logic exp_ill);
    int cyc;
    int w;
    w = 0;
    while (!rdy[d] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq({tag, " ready"}, 32'(rdy[d]), 32'd1);
    vld[d]   = 1'b1;
    ins_a[d] = ins;
    pc_a[d]  = pcn;
    @(posedge clk); #1;
    vld[d]   = 1'b0;
    ins_a[d] = 32'hDEAD_BEEF;
    pc_a[d]  = 32'hFFFF_FFFF;
    cyc = 1;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!dn[d] && cyc < 100);
    check_eq({tag, " lat"}, 32'(cyc), 32'(exp_lat));
    check_eq({tag, " illegal"}, 32'(ill[d]), 32'(exp_ill));
    @(posedge clk); #1;
    check_eq({tag, " done pulse"}, 32'(dn[d]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    for (int i = 0; i < 3; i++) begin
      vld[i] = 1'b0; ins_a[i] = 32'h0; pc_a[i] = 32'h0; dba[i] = 5'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check_eq("rst ready", 32'(rdy[0]), 32'd1);
    check_eq("rst busy", 32'(bsy[0]), 32'd0);
    check_eq("rst done", 32'(dn[0]), 32'd0);
    check_eq("rst illegal", 32'(ill[0]), 32'd0);

    // RV32I, one bit per shift cycle
    issue(0, enc_i(12'hFFB, 5'd0, 3'b000, 5'd1, OP_IMM), 32'h0, "addi x1", 2, 1'b0);
    check_reg(0, 5'd1, 32'hFFFF_FFFB, "x1");
    issue(0, enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2), 32'h0, "add x2", 2, 1'b0);
    check_reg(0, 5'd2, 32'hFFFF_FFF6, "x2");
    issue(0, enc_u(20'h12345, 5'd3, LUI), 32'h0, "lui x3", 2, 1'b0);
    check_reg(0, 5'd3, 32'h1234_5000, "x3");
    issue(0, enc_u(20'h00000, 5'd4, JAL), 32'h0000_0104, "jal x4", 2, 1'b0);
    check_reg(0, 5'd4, 32'h0000_0104, "x4");
    issue(0, enc_u(20'h80000, 5'd5, LUI), 32'h0, "lui x5", 2, 1'b0);
    issue(0, enc_i({7'b0100000, 5'd31}, 5'd5, 3'b101, 5'd6, OP_IMM), 32'h0, "srai31", 33, 1'b0);
    check_reg(0, 5'd6, 32'hFFFF_FFFF, "x6");
    issue(0, enc_i({7'b0000000, 5'd31}, 5'd5, 3'b101, 5'd11, OP_IMM), 32'h0, "srli31", 33, 1'b0);
    check_reg(0, 5'd11, 32'h0000_0001, "x11");
    issue(0, enc_i(12'hFFF, 5'd0, 3'b000, 5'd7, OP_IMM), 32'h0, "addi x7", 2, 1'b0);
    issue(0, enc_i(12'h001, 5'd0, 3'b000, 5'd8, OP_IMM), 32'h0, "addi x8", 2, 1'b0);
    issue(0, enc_r(7'b0000000, 5'd8, 5'd7, 3'b010, 5'd9), 32'h0, "slt", 2, 1'b0);
    check_reg(0, 5'd9, 32'h0000_0001, "x9 slt");
    issue(0, enc_r(7'b0000000, 5'd8, 5'd7, 3'b011, 5'd12), 32'h0, "sltu", 2, 1'b0);
    check_reg(0, 5'd12, 32'h0000_0000, "x12 sltu");
    issue(0, enc_u(20'h80000, 5'd13, LUI), 32'h0, "lui x13", 2, 1'b0);
    issue(0, enc_i(12'hFFF, 5'd13, 3'b000, 5'd13, OP_IMM), 32'h0, "addi x13", 2, 1'b0);
    check_reg(0, 5'd13, 32'h7FFF_FFFF, "x13");
    issue(0, enc_i(12'h001, 5'd13, 3'b000, 5'd14, OP_IMM), 32'h0, "wrap", 2, 1'b0);
    check_reg(0, 5'd14, 32'h8000_0000, "x14 wrap");
    issue(0, enc_i(12'h000, 5'd5, 3'b001, 5'd15, OP_IMM), 32'h0, "slli0", 2, 1'b0);
    check_reg(0, 5'd15, 32'h8000_0000, "x15");
    issue(0, enc_r(7'b0100000, 5'd1, 5'd2, 3'b000, 5'd16), 32'h0, "sub", 2, 1'b0);
    check_reg(0, 5'd16, 32'hFFFF_FFFB, "x16 sub");
    issue(0, enc_r(7'b0000000, 5'd11, 5'd8, 3'b001, 5'd17), 32'h0, "sll reg", 3, 1'b0);
    check_reg(0, 5'd17, 32'h0000_0002, "x17 sll");
    issue(0, enc_r(7'b0100000, 5'd8, 5'd8, 3'b001, 5'd18), 32'h0, "bad f7", 2, 1'b1);
    check_reg(0, 5'd18, 32'h0000_0000, "x18 unwritten");
    issue(0, enc_r(7'b0000000, 5'd2, 5'd1, 3'b110, 5'd19), 32'h0, "or", 2, 1'b0);
    check_reg(0, 5'd19, 32'hFFFF_FFFF, "x19 or");

    // RV32I, four bits per shift cycle
    issue(1, enc_u(20'h80000, 5'd5, LUI), 32'h0, "s4 lui", 2, 1'b0);
    issue(1, enc_i({7'b0100000, 5'd31}, 5'd5, 3'b101, 5'd6, OP_IMM), 32'h0, "s4 srai31", 10, 1'b0);
    check_reg(1, 5'd6, 32'hFFFF_FFFF, "s4 x6");
    issue(1, enc_i({7'b0000000, 5'd4}, 5'd5, 3'b101, 5'd7, OP_IMM), 32'h0, "s4 srli4", 3, 1'b0);
    check_reg(1, 5'd7, 32'h0800_0000, "s4 x7");
    issue(1, enc_i({7'b0100000, 5'd5}, 5'd5, 3'b101, 5'd8, OP_IMM), 32'h0, "s4 srai5", 4, 1'b0);
    check_reg(1, 5'd8, 32'hFC00_0000, "s4 x8");

    // RV32E register-count limits
    issue(2, enc_i(12'h001, 5'd0, 3'b000, 5'd17, OP_IMM), 32'h0, "e rd17", 2, 1'b1);
    check_reg(2, 5'd17, 32'h0000_0000, "e x17");
    check_reg(2, 5'd1, 32'h0000_0000, "e x1 after rd17");
    issue(2, enc_i(12'h000, 5'd0, 3'b010, 5'd1, LOAD), 32'h0, "e load", 2, 1'b1);
    issue(2, enc_i(12'h007, 5'd0, 3'b000, 5'd0, OP_IMM), 32'h0, "e x0 write", 2, 1'b0);
    check_reg(2, 5'd0, 32'h0000_0000, "e x0");
    issue(2, enc_i(12'h007, 5'd0, 3'b000, 5'd15, OP_IMM), 32'h0, "e rd15", 2, 1'b0);
    check_reg(2, 5'd15, 32'h0000_0007, "e x15");
    issue(2, enc_r(7'b0000000, 5'd16, 5'd15, 3'b000, 5'd1), 32'h0, "e rs2 16", 2, 1'b1);
    check_reg(2, 5'd1, 32'h0000_0000, "e x1 after rs2");

    // Reset in the middle of SLLI x10,x5,20
    vld[0]   = 1'b1;
    ins_a[0] = enc_i({7'b0000000, 5'd20}, 5'd5, 3'b001, 5'd10, OP_IMM);
    @(posedge clk); #1;
    vld[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("mid shift busy", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post rst ready", 32'(rdy[0]), 32'd1);
    check_eq("post rst busy", 32'(bsy[0]), 32'd0);
    n_done = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (dn[0]) n_done++;
    end
    check_eq("post rst done count", 32'(n_done), 32'd0);
    check_reg(0, 5'd10, 32'h0000_0000, "post rst x10");
    check_reg(0, 5'd5, 32'h0000_0000, "post rst x5");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_unit_mc.md
Name: exec_unit_mc

Overview:
- Multi-cycle execute/writeback unit for the RV32I integer subset.
- Successor to the single-cycle decode/ALU/register-file datapath.
- Accepts one instruction per handshake, reads its own register file, computes the result and writes it back.
- New relative to the single-cycle datapath: parametrised register count (RV32E/RV32I), full shift support through an iterative shifter, illegal-instruction flagging, busy/done handshake.

Parameters:
- NREGS, 32, architectural register count; legal values 16 (RV32E) or 32.
- SHIFT_STEP, 1, bits shifted per cycle by the iterative shifter; power of two, 1..32.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- instr_valid  in  1  instruction and pc_next are valid.
- instr_ready  out  1  unit can accept an instruction; high only in IDLE.
- instruction  in  32  RV32 instruction word.
- pc_next  in  32  PC+4 of the instruction; the link value for JAL.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in WB.
- illegal  out  1  valid with done; the retired instruction was unsupported.
- dbg_addr  in  5  debug register read address.
- dbg_data  out  32  combinational read of register dbg_addr; reads 0 for x0 or when dbg_addr >= NREGS.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE; all registers x0..x(NREGS-1) are cleared to 0.
  - done=0, illegal=0, busy=0, instr_ready=1 from the next cycle.
  - Reset in any state aborts the instruction in flight; no writeback occurs.
- States: IDLE, EXEC, SHIFT, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid=1, latch instruction and pc_next, then go to EXEC.
  - instruction and pc_next are ignored outside IDLE.
- EXEC:
  - Decode the latched word and read rs1/rs2 from the register file.
  - Supported operations:
    - OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
    - OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
    - LUI (0110111): result = {instr[31:12], 12'h000}.
    - JAL (1101111): result = pc_next.
  - Immediates are sign-extended from instr[31:20].
  - Shift amount is instr[24:20] for immediate shifts and rs2[4:0] for register shifts.
  - Shift with amount > 0: load the shifter, go to SHIFT. All other cases: go to WB.
- SHIFT:
  - Each cycle, shift by min(SHIFT_STEP, remaining) and decrement remaining by that amount.
  - SRA fills vacated bits with the original bit 31; SLL and SRL fill with zeros.
  - When remaining reaches 0 at the end of a cycle, go to WB.
- WB:
  - done=1 for exactly this cycle.
  - Write the result to rd if the instruction is legal and rd != 0.
  - Go to IDLE.
- Latency, counted from the accept edge:
  - Non-shift, or shift by 0: done is asserted 2 cycles later.
  - Shift by n>0: done is asserted 2 + ceil(n/SHIFT_STEP) cycles later.
- Illegal instruction (illegal=1 with done, no register write):
  - Any unlisted opcode.
  - funct7 not 0000000 (or 0100000 for SUB/SRA/SRAI).
  - Any of rd/rs1/rs2 >= NREGS when the instruction uses it.
- x0: always reads 0; writes to x0 are dropped.
- Arithmetic: all results are 32-bit with wrap-around (0x7FFFFFFF + 1 = 0x80000000). SLT is signed, SLTU is unsigned; both produce 0 or 1.
- Back-to-back instructions:
  - The earliest next accept is the cycle after WB.
  - A register written in WB is visible to the next instruction's EXEC; there is no hazard.
- dbg_data reflects a write on the cycle after WB.

Decomposition:
- Shared package exec_pkg holds:
  - opcode constants OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_JAL;
  - funct3 constants;
  - the state enum (IDLE, EXEC, SHIFT, WB);
  - the ALU operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- One sub-module, iter_shifter, parametrised by SHIFT_STEP:
  - Inputs: load, value, amount, kind.
  - Outputs: result, finished.

Test Plan:
- ADDI x1,x0,-5 then ADD x2,x1,x1 → x1=0xFFFFFFFB, x2=0xFFFFFFF6; each done pulse arrives 2 cycles after accept.
- LUI x3,0x12345 then JAL x4 with pc_next=0x00000104 → x3=0x12345000, x4=0x00000104.
- x5=0x80000000, SRAI x6,x5,31 with SHIFT_STEP=1 → x6=0xFFFFFFFF after 33 cycles; SRLI gives 0x00000001; with SHIFT_STEP=4, latency is 10.
- SLT/SLTU with x7=-1, x8=1 → SLT x9,x7,x8 gives 1; SLTU gives 0.
- NREGS=16: ADDI x17,x0,1 → illegal=1 with done, no write. Opcode 0000011 (LOAD) → illegal=1. ADDI x0,x0,7 → x0 still reads 0.
- Reset: drop rst_n during SHIFT of SLLI x10,x5,20 → no write, done never pulses, x10=0, instr_ready=1 the cycle after rst_n returns high.
